// File: rtl/t05_htree_pkg.sv
// rtl/t05_htree_pkg.sv - shared types, node field layout and address helper for the tree-build scheduler
package t05_htree_pkg;

  localparam int NODE_W = 71;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 7;
  localparam int ADDR_W = 9;

  localparam int IDX_HI = 70;
  localparam int IDX_LO = 64;
  localparam int L1_HI  = 63;
  localparam int L1_LO  = 55;
  localparam int L2_HI  = 54;
  localparam int L2_LO  = 46;
  localparam int SUM_HI = 45;
  localparam int SUM_LO = 0;

  localparam logic [3:0] HT_EN_RUN = 4'b0011;

  typedef enum logic [3:0] {
    IDLE,
    FL_REQ,
    FL_WAIT,
    HT_RUN,
    HT_RD,
    CAPTURE,
    WR_TREE,
    WR_NULL1,
    WR_NULL2,
    NEXT,
    DONE,
    ERR
  } state_t;

  // Word address of node idx; the sum wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] node_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + {{(ADDR_W-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/t05_htsched_sram_if.sv
// rtl/t05_htsched_sram_if.sv - single-outstanding SRAM request holder with optional ack watchdog
// Watchdog present only when T05_HTSCHED_TIMEOUT_EN is defined.
module t05_htsched_sram_if
  import t05_htree_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [NODE_W-1:0] cmd_wdata,
  input  logic              sram_ack,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [NODE_W-1:0] sram_wdata,
  output logic              ack_hit,
  output logic              timeout
);

  logic wd_expire;

  // An ack only counts while a request is actually outstanding.
  assign ack_hit = sram_req & sram_ack;

`ifdef T05_HTSCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = sram_req && !sram_ack && (wd_cnt == WD_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_expire;
      if (cmd_valid || wd_expire || !sram_req || sram_ack) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // A new command may be loaded on the ack cycle, so back-to-back writes keep req high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_req   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (cmd_valid) begin
      sram_req   <= 1'b1;
      sram_we    <= cmd_we;
      sram_addr  <= cmd_addr;
      sram_wdata <= cmd_wdata;
    end else if (ack_hit || wd_expire) begin
      sram_req   <= 1'b0;
    end
  end

endmodule

// File: rtl/t05_htree_sched.sv
// rtl/t05_htree_sched.sv - tree-build sequencer and node SRAM owner
// Define T05_HTSCHED_TIMEOUT_EN to enable the SRAM ack watchdog.
module t05_htree_sched
  import t05_htree_pkg::*;
#(
  parameter int NODE_BASE   = 0,
  parameter int MAX_NODES   = 127,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              fl_start,
  input  logic              fl_done,
  output logic [3:0]        ht_en,
  input  logic              ht_wor,
  input  logic [IDX_W-1:0]  ht_idx,
  input  logic              ht_fin,
  input  logic              ht_finished,
  input  logic              ht_err,
  input  logic [NODE_W-1:0] tree_node,
  input  logic [NODE_W-1:0] null1,
  input  logic [NODE_W-1:0] null2,
  output logic [DATA_W-1:0] nulls,
  output logic              sram_finished,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [NODE_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic [IDX_W-1:0]  node_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(NODE_BASE);

  state_t            state;
  logic [NODE_W-1:0] tree_q;
  logic [NODE_W-1:0] null1_q;
  logic [NODE_W-1:0] null2_q;
  logic              v1;
  logic              v2;
  logic [IDX_W-1:0]  nc_inc;

  logic              cmd_valid;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [NODE_W-1:0] cmd_wdata;
  logic              ack_hit;
  logic              timeout;

  assign v1     = tree_q[L1_HI];
  assign v2     = tree_q[L2_HI];
  assign nc_inc = node_count + 1'b1;

  // Requests are issued on the transition into the owning state, so each
  // access occupies its state from the first cycle.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    case (state)
      HT_RUN: begin
        if (!ht_err && !ht_finished && ht_wor) begin
          cmd_valid = 1'b1;
          cmd_addr  = node_addr(BASE, ht_idx);
        end
      end
      CAPTURE: begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = node_addr(BASE, node_count);
        cmd_wdata = tree_node;
      end
      WR_TREE: begin
        if (ack_hit && (v1 || v2)) begin
          cmd_valid = 1'b1;
          cmd_we    = 1'b1;
          if (v1) begin
            cmd_addr  = node_addr(BASE, null1_q[IDX_HI:IDX_LO]);
            cmd_wdata = null1_q;
          end else begin
            cmd_addr  = node_addr(BASE, null2_q[IDX_HI:IDX_LO]);
            cmd_wdata = null2_q;
          end
        end
      end
      WR_NULL1: begin
        if (ack_hit && v2) begin
          cmd_valid = 1'b1;
          cmd_we    = 1'b1;
          cmd_addr  = node_addr(BASE, null2_q[IDX_HI:IDX_LO]);
          cmd_wdata = null2_q;
        end
      end
      default: ;
    endcase
  end

  t05_htsched_sram_if #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_sram_if (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .sram_ack   (sram_ack),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .ack_hit    (ack_hit),
    .timeout    (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fl_start      <= 1'b0;
      ht_en         <= '0;
      nulls         <= '0;
      sram_finished <= 1'b0;
      node_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      tree_q        <= '0;
      null1_q       <= '0;
      null2_q       <= '0;
    end else begin
      fl_start      <= 1'b0;
      sram_finished <= 1'b0;
      if (timeout) begin
        state <= ERR;
        error <= 1'b1;
        busy  <= 1'b0;
        ht_en <= '0;
      end else begin
        case (state)
          IDLE, DONE, ERR: begin
            if (start) begin
              state      <= FL_REQ;
              fl_start   <= 1'b1;
              node_count <= '0;
              done       <= 1'b0;
              error      <= 1'b0;
              busy       <= 1'b1;
            end
          end
          FL_REQ: state <= FL_WAIT;
          FL_WAIT: begin
            if (fl_done) begin
              state <= HT_RUN;
              ht_en <= HT_EN_RUN;
            end
          end
          HT_RUN: begin
            if (ht_err) begin
              state <= ERR;
              error <= 1'b1;
              busy  <= 1'b0;
              ht_en <= '0;
            end else if (ht_finished) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              ht_en <= '0;
            end else if (ht_wor) begin
              state <= HT_RD;
            end else if (ht_fin) begin
              state <= CAPTURE;
            end
          end
          HT_RD: begin
            if (ack_hit) begin
              nulls         <= sram_rdata;
              sram_finished <= 1'b1;
              state         <= HT_RUN;
            end
          end
          // The builder clears its outputs once ht_en drops, so keep copies.
          CAPTURE: begin
            tree_q  <= tree_node;
            null1_q <= null1;
            null2_q <= null2;
            ht_en   <= '0;
            state   <= WR_TREE;
          end
          WR_TREE: begin
            if (ack_hit) begin
              state <= v1 ? WR_NULL1 : (v2 ? WR_NULL2 : NEXT);
            end
          end
          WR_NULL1: begin
            if (ack_hit) begin
              state <= v2 ? WR_NULL2 : NEXT;
            end
          end
          WR_NULL2: begin
            if (ack_hit) begin
              state <= NEXT;
            end
          end
          NEXT: begin
            node_count <= nc_inc;
            if (nc_inc == IDX_W'(MAX_NODES)) begin
              state <= ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= FL_REQ;
              fl_start <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
